// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default sizing
// constants and the clear-sweep FSM state encoding.
package regfile_mp_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned N_READ_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_mp_clr_fsm.sv
// Clear-sweep controller for regfile_mp. On clr_req_i in IDLE it walks the
// register index from the first clearable register up to DEPTH-1, asking the
// array to zero one register per cycle, then pulses clr_done_o once.
// Ports:
//   clk, clr_n     clock, asynchronous active-low reset
//   clr_req_i      start a sweep (ignored while sweeping)
//   busy_o         sweep in progress (registered)
//   w_ready_o      writes accepted, always ~busy_o (registered)
//   clr_done_o     one-cycle pulse in the cycle after the last clear (registered)
//   sweep_we_o     zero the register at sweep_idx_o on the next edge
//   sweep_idx_o    register currently being cleared
module regfile_mp_clr_fsm
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              w_ready_o,
  output logic              clr_done_o,
  output logic              sweep_we_o,
  output logic [ADDR_W-1:0] sweep_idx_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  // One extra bit so the terminal compare never aliases through a wrap.
  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'((ZERO_REG != 0) ? 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH - 1);

  clr_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  // State and registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_SWEEP;
          idx_d   = IDX_FIRST;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      ST_SWEEP: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    endcase
  end

  assign busy_o      = busy_q;
  assign w_ready_o   = ready_q;
  assign clr_done_o  = done_q;
  assign sweep_we_o  = (state_q == ST_SWEEP);
  assign sweep_idx_o = idx_q[ADDR_W-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: N_READ combinational read ports,
// two prioritised write ports (w1 = late/load writeback beats w0 = ALU
// writeback on an address clash) and a multi-cycle hardware clear sweep.
// Optional feature macro: REGFILE_MP_BYPASS_EN adds same-cycle
// write-to-read forwarding (w1 over w0); without it reads show array state.
// Ports:
//   clk, clr_n            clock, asynchronous active-low reset
//   r_number / data_out   packed read addresses / read data, port k at slice k
//   w0_* / w1_*           write ports (number, data, enable)
//   w_ready               writes accepted this cycle (low during a sweep)
//   clr_req               start a clear sweep
//   busy                  clear sweep in progress
//   clr_done              one-cycle pulse when the sweep finishes
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned N_READ   = N_READ_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [N_READ*ADDR_W-1:0] r_number,
  output logic [N_READ*DATA_W-1:0] data_out,
  input  logic [ADDR_W-1:0]        w0_number,
  input  logic [DATA_W-1:0]        w0_data,
  input  logic                     w0_en,
  input  logic [ADDR_W-1:0]        w1_number,
  input  logic [DATA_W-1:0]        w1_data,
  input  logic                     w1_en,
  output logic                     w_ready,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_idx;
  logic              w0_acc;
  logic              w1_acc;

  regfile_mp_clr_fsm #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_clr_fsm (
    .clk         (clk),
    .clr_n       (clr_n),
    .clr_req_i   (clr_req),
    .busy_o      (busy),
    .w_ready_o   (w_ready),
    .clr_done_o  (clr_done),
    .sweep_we_o  (sweep_we),
    .sweep_idx_o (sweep_idx)
  );

  // A write is accepted only when ready and not aimed at a hardwired zero.
  assign w0_acc = w0_en && w_ready && ((ZERO_REG == 0) || (w0_number != '0));
  assign w1_acc = w1_en && w_ready && ((ZERO_REG == 0) || (w1_number != '0));

  // Array update: w1 applied after w0 so it wins a same-address clash.
  // Sweep and writes are mutually exclusive because w_ready is low in SWEEP.
  always_comb begin
    mem_d = mem_q;
    if (w0_acc) mem_d[w0_number] = w0_data;
    if (w1_acc) mem_d[w1_number] = w1_data;
    if (sweep_we) mem_d[sweep_idx] = '0;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports.
  for (genvar k = 0; k < N_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = r_number[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem_q[ra];
      if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
`ifdef REGFILE_MP_BYPASS_EN
      // Forward in-flight write data; w1 checked last to keep its priority.
      if (w0_acc && (w0_number == ra)) rd = w0_data;
      if (w1_acc && (w1_number == ra)) rd = w1_data;
`endif
    end

    assign data_out[k*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters) plus a second
// instance with ZERO_REG=0 for the register-0 behaviour.
module tb_regfile_mp;

  logic        clk;
  logic        clr_n;
  logic [9:0]  r_number;
  logic [63:0] data_out;
  logic [4:0]  w0_number;
  logic [31:0] w0_data;
  logic        w0_en;
  logic [4:0]  w1_number;
  logic [31:0] w1_data;
  logic        w1_en;
  logic        w_ready;
  logic        clr_req;
  logic        busy;
  logic        clr_done;

  logic [31:0] nz_data_out;
  logic        nz_w_ready;
  logic        nz_busy;
  logic        nz_clr_done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [32];
  logic        ready_m;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  regfile_mp u_dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .r_number  (r_number),
    .data_out  (data_out),
    .w0_number (w0_number),
    .w0_data   (w0_data),
    .w0_en     (w0_en),
    .w1_number (w1_number),
    .w1_data   (w1_data),
    .w1_en     (w1_en),
    .w_ready   (w_ready),
    .clr_req   (clr_req),
    .busy      (busy),
    .clr_done  (clr_done)
  );

  regfile_mp #(.N_READ(1), .ZERO_REG(0)) u_dut_nz (
    .clk       (clk),
    .clr_n     (clr_n),
    .r_number  (r_number[4:0]),
    .data_out  (nz_data_out),
    .w0_number (w0_number),
    .w0_data   (w0_data),
    .w0_en     (w0_en),
    .w1_number (w1_number),
    .w1_data   (w1_data),
    .w1_en     (w1_en),
    .w_ready   (nz_w_ready),
    .clr_req   (clr_req),
    .busy      (nz_busy),
    .clr_done  (nz_clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  // Read two addresses now; expectations may be overridden for bypass cases.
  task automatic rd_exp(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] e0, input logic [31:0] e1);
    r_number = {a1, a0};
    push($sformatf("rd0_a%0d", a0), e0);
    push($sformatf("rd1_a%0d", a1), e1);
    #1;
    pop_chk(data_out[31:0]);
    pop_chk(data_out[63:32]);
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_exp(a0, a1, model_rd(a0), model_rd(a1));
  endtask

  task automatic drive_w(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    w0_en = e0; w0_number = a0; w0_data = d0;
    w1_en = e1; w1_number = a1; w1_data = d1;
  endtask

  // Advance one rising edge, applying accepted writes to the model.
  task automatic step();
    @(posedge clk);
    if (ready_m) begin
      if (w0_en && (w0_number != 5'd0)) model[w0_number] = w0_data;
      if (w1_en && (w1_number != 5'd0)) model[w1_number] = w1_data;
    end
    #1;
    w0_en   = 1'b0;
    w1_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic rd_all();
    for (int a = 0; a < 32; a += 2) begin
      @(negedge clk);
      rd(5'(a), 5'(a + 1));
    end
  endtask

  logic        bypass_on;
  int          busy_cnt;
  int          done_cnt;
  int          done_k;
  logic [31:0] e_same;

  initial begin
`ifdef REGFILE_MP_BYPASS_EN
    bypass_on = 1'b1;
`else
    bypass_on = 1'b0;
`endif
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    ready_m  = 1'b1;
    clr_n    = 1'b1;
    r_number = '0;
    clr_req  = 1'b0;
    drive_w(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Reset
    #2 clr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(clr_done), 32'd0);
    chk("rst_w_ready", 32'(w_ready), 32'd1);
    clr_n = 1'b1;
    rd_all();
    chk("idle_w_ready", 32'(w_ready), 32'd1);

    // Same-address conflict: w1 wins
    @(posedge clk); #1;
    drive_w(1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222);
    e_same = bypass_on ? 32'h2222_2222 : 32'd0;
    rd_exp(5'd7, 5'd7, e_same, e_same);
    step();
    rd(5'd7, 5'd7);

    // Two different addresses commit together
    drive_w(1'b1, 5'd8, 32'hA5A5_0008, 1'b1, 5'd9, 32'h5A5A_0009);
    step();
    rd(5'd8, 5'd9);

    // Register 0: hardwired in default build, ordinary with ZERO_REG=0
    drive_w(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    rd_exp(5'd0, 5'd0, 32'd0, 32'd0);
    step();
    rd(5'd0, 5'd0);
    chk("nz_reg0", nz_data_out, 32'hDEAD_BEEF);

    // Bypass/visibility of a write to address 3
    drive_w(1'b1, 5'd3, 32'hCAFE_0001, 1'b0, 5'd0, 32'd0);
    e_same = bypass_on ? 32'hCAFE_0001 : 32'd0;
    rd_exp(5'd3, 5'd3, e_same, e_same);
    step();
    rd(5'd3, 5'd3);

    // Fill 1..31 with their index
    for (int i = 1; i < 32; i++) begin
      drive_w(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'd0);
      step();
    end
    rd(5'd1, 5'd31);

    // Clear sweep
    clr_req = 1'b1;
    step();
    ready_m = 1'b0;
    chk("sweep_busy_rise", 32'(busy), 32'd1);
    chk("sweep_w_ready", 32'(w_ready), 32'd0);
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    done_k   = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 2) begin
        // Dropped write plus an ignored re-request while busy
        drive_w(1'b1, 5'd5, 32'h55AA_55AA, 1'b0, 5'd0, 32'd0);
        clr_req = 1'b1;
      end
      step();
      if (k <= 31) model[k] = 32'd0;
      if (done_cnt > 0) begin
        chk("done_one_cycle", 32'(clr_done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        break;
      end
      if (busy) busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        done_k = k;
      end
      if (k == 2) rd(5'd5, 5'd2);
      if (k == 10) begin
        for (int a = 1; a <= 10; a += 2) rd(5'(a), 5'(a + 1));
        rd(5'd20, 5'd11);
      end
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd31);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_cycle", 32'(done_k), 32'd31);
    ready_m = 1'b1;
    rd_all();

    // Reset in the middle of a sweep
    drive_w(1'b1, 5'd20, 32'd20, 1'b1, 5'd30, 32'd30);
    step();
    clr_req = 1'b1;
    step();
    ready_m = 1'b0;
    repeat (15) step();
    rd(5'd20, 5'd30);
    clr_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(clr_done), 32'd0);
    chk("abort_w_ready", 32'(w_ready), 32'd1);
    rd(5'd20, 5'd30);
    @(posedge clk); #1;
    clr_n   = 1'b1;
    ready_m = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (clr_done) done_cnt++;
      if (busy) busy_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_no_busy", 32'(busy_cnt), 32'd0);

    // Writes work again after the aborted sweep
    drive_w(1'b1, 5'd12, 32'h0000_0012, 1'b0, 5'd0, 32'd0);
    step();
    rd(5'd12, 5'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
